// File: rtl/lcd_rect_writer_if.sv
// Handshake bundle between a rectangle/pixel source, the sequencer and the SPI shifter.
interface lcd_rect_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x0;
  logic [7:0] req_y0;
  logic [7:0] req_x1;
  logic [7:0] req_y1;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [8:0] tx_word;
  logic       busy;
  logic       done;
  logic       err;

  // Source side: issues requests and pixels, plays the serializer role on tx.
  modport master (
    output req_valid, req_x0, req_y0, req_x1, req_y1,
    output pix_valid, pix_data,
    output tx_ready,
    input  req_ready, pix_ready, tx_valid, tx_word, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_x0, req_y0, req_x1, req_y1,
    input  pix_valid, pix_data,
    input  tx_ready,
    output req_ready, pix_ready, tx_valid, tx_word, busy, done, err
  );
endinterface

// File: rtl/lcd_rect_writer.sv
// ST7735 rectangle writer: emits CASET/RASET/RAMWR as {dc,byte} words, then
// streams RGB565 pixels high byte first through a single output register.
module lcd_rect_writer #(
  parameter int unsigned LCD_W   = 132,
  parameter int unsigned LCD_H   = 162,
  parameter int unsigned COL_OFS = 0,
  parameter int unsigned ROW_OFS = 0
) (
  input logic              clk,
  input logic              rst,
  lcd_rect_writer_if.slave bus
);
  localparam logic [8:0] LcdW   = 9'(LCD_W);
  localparam logic [8:0] LcdH   = 9'(LCD_H);
  localparam logic [7:0] ColOfs = 8'(COL_OFS);
  localparam logic [7:0] RowOfs = 8'(ROW_OFS);

  typedef enum logic [2:0] {StIdle, StHdr, StPixHi, StPixLo, StDrain} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_tx_valid, w_tx_valid_nxt;
  logic [8:0]  r_tx_word, w_tx_word_nxt;
  logic [3:0]  r_hdr_idx, w_hdr_idx_nxt;
  logic [15:0] r_remain, w_remain_nxt;
  logic [7:0]  r_lo, w_lo_nxt;
  logic [7:0]  r_x0, r_x1, r_y0, r_y1;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        w_free, w_legal, w_load_req, w_pix_ready;
  logic [8:0]  w_width, w_height, w_hdr_word;
  logic [15:0] w_npix;
  logic [7:0]  w_cs, w_ce, w_rs, w_re;

  // Output register can take a new word when empty or being handed off now.
  assign w_free   = !r_tx_valid || bus.tx_ready;
  assign w_legal  = (bus.req_x0 <= bus.req_x1) && ({1'b0, bus.req_x1} < LcdW) &&
                    (bus.req_y0 <= bus.req_y1) && ({1'b0, bus.req_y1} < LcdH);
  assign w_width  = {1'b0, bus.req_x1} - {1'b0, bus.req_x0} + 9'd1;
  assign w_height = {1'b0, bus.req_y1} - {1'b0, bus.req_y0} + 9'd1;
  // Largest legal product is 132*162, so 16 bits never overflow.
  assign w_npix   = {7'd0, w_width} * {7'd0, w_height};

  // Panel offsets wrap modulo 256 by construction.
  assign w_cs = r_x0 + ColOfs;
  assign w_ce = r_x1 + ColOfs;
  assign w_rs = r_y0 + RowOfs;
  assign w_re = r_y1 + RowOfs;

  // Header word table indexed by position within the 11-word window preamble.
  always_comb begin
    w_hdr_word = 9'h02C;
    case (r_hdr_idx)
      4'd0:    w_hdr_word = 9'h02A;
      4'd1:    w_hdr_word = 9'h100;
      4'd2:    w_hdr_word = {1'b1, w_cs};
      4'd3:    w_hdr_word = 9'h100;
      4'd4:    w_hdr_word = {1'b1, w_ce};
      4'd5:    w_hdr_word = 9'h02B;
      4'd6:    w_hdr_word = 9'h100;
      4'd7:    w_hdr_word = {1'b1, w_rs};
      4'd8:    w_hdr_word = 9'h100;
      4'd9:    w_hdr_word = {1'b1, w_re};
      default: w_hdr_word = 9'h02C;
    endcase
  end

  // Next-state, output-register load and pixel handshake decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_word_nxt  = r_tx_word;
    w_hdr_idx_nxt  = r_hdr_idx;
    w_remain_nxt   = r_remain;
    w_lo_nxt       = r_lo;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_load_req     = 1'b0;
    w_pix_ready    = 1'b0;
    // A word handed off this cycle empties the register unless refilled below.
    if (r_tx_valid && bus.tx_ready) w_tx_valid_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          if (w_legal) begin
            w_load_req     = 1'b1;
            w_state_nxt    = StHdr;
            w_tx_valid_nxt = 1'b1;
            w_tx_word_nxt  = 9'h02A;
            w_hdr_idx_nxt  = 4'd1;
            w_remain_nxt   = w_npix;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      StHdr: begin
        if (w_free) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_word_nxt  = w_hdr_word;
          // Enter pixel phase as RAMWR loads so the first pixel can follow back-to-back.
          if (r_hdr_idx == 4'd10) begin
            w_state_nxt   = StPixHi;
            w_hdr_idx_nxt = 4'd0;
          end else begin
            w_hdr_idx_nxt = r_hdr_idx + 4'd1;
          end
        end
      end
      StPixHi: begin
        w_pix_ready = w_free;
        if (w_free && bus.pix_valid) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_word_nxt  = {1'b1, bus.pix_data[15:8]};
          w_lo_nxt       = bus.pix_data[7:0];
          w_state_nxt    = StPixLo;
        end
      end
      StPixLo: begin
        if (w_free) begin
          w_tx_valid_nxt = 1'b1;
          w_tx_word_nxt  = {1'b1, r_lo};
          w_remain_nxt   = r_remain - 16'd1;
          w_state_nxt    = (r_remain == 16'd1) ? StDrain : StPixHi;
        end
      end
      StDrain: begin
        if (r_tx_valid && bus.tx_ready) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_tx_valid <= 1'b0;
      r_tx_word  <= 9'd0;
      r_hdr_idx  <= 4'd0;
      r_remain   <= 16'd0;
      r_lo       <= 8'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_x0       <= 8'd0;
      r_x1       <= 8'd0;
      r_y0       <= 8'd0;
      r_y1       <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_word  <= w_tx_word_nxt;
      r_hdr_idx  <= w_hdr_idx_nxt;
      r_remain   <= w_remain_nxt;
      r_lo       <= w_lo_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      if (w_load_req) begin
        r_x0 <= bus.req_x0;
        r_x1 <= bus.req_x1;
        r_y0 <= bus.req_y0;
        r_y1 <= bus.req_y1;
      end
    end
  end

  assign bus.req_ready = (r_state == StIdle);
  assign bus.pix_ready = w_pix_ready;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_word   = r_tx_word;
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_lcd_rect_writer.sv
// Directed bench for lcd_rect_writer: one default instance, one with panel offsets.
module tb_lcd_rect_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_rect_writer_if bus ();
  lcd_rect_writer_if bus2 ();

  lcd_rect_writer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lcd_rect_writer #(
    .LCD_W   (132),
    .LCD_H   (162),
    .COL_OFS (2),
    .ROW_OFS (1)
  ) u_dut_ofs (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int         n_vec = 0;
  int         n_miss = 0;
  logic [8:0] q[$];
  logic [8:0] q2[$];
  int         pcnt = 0, pcnt2 = 0, ndone = 0, ndone2 = 0, nerr = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = 9'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output bit seen, output int busy_low);
    seen = 1'b0;
    busy_low = 0;
    for (int i = 0; i < bound; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (!bus.busy) busy_low++;
      tick();
    end
  endtask

  task automatic req(input logic [7:0] x0, input logic [7:0] y0,
                     input logic [7:0] x1, input logic [7:0] y1);
    bus.req_valid = 1'b1;
    bus.req_x0 = x0;
    bus.req_y0 = y0;
    bus.req_x1 = x1;
    bus.req_y1 = y1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Handshake monitor plus hold check on stalled output words.
  always @(posedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) q.push_back(bus.tx_word);
      if (bus.pix_valid && bus.pix_ready) pcnt++;
      if (bus.done) ndone++;
      if (bus.err) nerr++;
      if (bus2.tx_valid && bus2.tx_ready) q2.push_back(bus2.tx_word);
      if (bus2.pix_valid && bus2.pix_ready) pcnt2++;
      if (bus2.done) ndone2++;
      if (prev_stall) begin
        n_vec++;
        assert ({bus.tx_valid, bus.tx_word} === {1'b1, prev_word}) else begin
          n_miss++;
          $error("FAIL stall_hold: got %h want %h", {bus.tx_valid, bus.tx_word},
                 {1'b1, prev_word});
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_word  = bus.tx_word;
    end
  end

  logic [8:0]  h_full[11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h183, 9'h02B,
                              9'h100, 9'h100, 9'h100, 9'h1A1, 9'h02C};
  logic [8:0]  e_ofs[13]  = '{9'h02A, 9'h100, 9'h107, 9'h100, 9'h107, 9'h02B,
                              9'h100, 9'h108, 9'h100, 9'h108, 9'h02C, 9'h107, 9'h1E0};
  logic [15:0] pixtab[4]  = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
  logic [8:0]  e_2x2[19]  = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B,
                              9'h100, 9'h100, 9'h100, 9'h101, 9'h02C,
                              9'h1A1, 9'h1B2, 9'h1C3, 9'h1D4, 9'h1E5, 9'h1F6,
                              9'h107, 9'h118};

  initial begin
    bit          seen;
    int          busy_low, base, d0, e0, nbad, cons, last, gap;
    logic [8:0]  ew;

    bus.req_valid = 0; bus.req_x0 = 0; bus.req_y0 = 0; bus.req_x1 = 0; bus.req_y1 = 0;
    bus.pix_valid = 0; bus.pix_data = 0; bus.tx_ready = 0;
    bus2.req_valid = 0; bus2.req_x0 = 0; bus2.req_y0 = 0; bus2.req_x1 = 0; bus2.req_y1 = 0;
    bus2.pix_valid = 0; bus2.pix_data = 0; bus2.tx_ready = 0;

    // Reset state
    tick(); tick();
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_word", bus.tx_word, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_pix_ready", bus.pix_ready, 0);
    rst = 1'b0;
    tick();

    // Full screen, constant red, no back-pressure
    q.delete(); base = pcnt; d0 = ndone;
    bus.tx_ready = 1; bus.pix_valid = 1; bus.pix_data = 16'hF800;
    req(8'd0, 8'd0, 8'd131, 8'd161);
    check("fs_first_valid", bus.tx_valid, 1);
    check("fs_first_word", bus.tx_word, 9'h02A);
    check("fs_busy", bus.busy, 1);
    check("fs_req_ready_busy", bus.req_ready, 0);
    wait_done(50000, seen, busy_low);
    check("fs_done_seen", seen, 1);
    check("fs_busy_low_cycles", busy_low, 0);
    check("fs_busy_at_done", bus.busy, 0);
    check("fs_req_ready_at_done", bus.req_ready, 1);
    check("fs_len", q.size(), 11 + 42768);
    if (q.size() == 11 + 42768) begin
      for (int k = 0; k < 11; k++) check($sformatf("fs_hdr%0d", k), q[k], h_full[k]);
      nbad = 0;
      for (int k = 0; k < 42768; k++) begin
        ew = (k % 2 == 0) ? 9'h1F8 : 9'h100;
        if (q[11 + k] !== ew) nbad++;
      end
      check("fs_pix_words_bad", nbad, 0);
    end
    tick(); tick(); tick();
    check("fs_pix_consumed", pcnt - base, 21384);
    check("fs_done_pulses", ndone - d0, 1);
    bus.pix_valid = 0;

    // 1x1 with offsets on the second instance
    q2.delete();
    bus2.tx_ready = 1; bus2.pix_valid = 1; bus2.pix_data = 16'h07E0;
    bus2.req_valid = 1; bus2.req_x0 = 5; bus2.req_y0 = 7; bus2.req_x1 = 5; bus2.req_y1 = 7;
    tick();
    bus2.req_valid = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus2.done) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("ofs_done_seen", seen, 1);
    tick(); tick();
    check("ofs_len", q2.size(), 13);
    if (q2.size() == 13)
      for (int k = 0; k < 13; k++) check($sformatf("ofs_w%0d", k), q2[k], e_ofs[k]);
    check("ofs_pix_consumed", pcnt2, 1);
    check("ofs_done_pulses", ndone2, 1);
    bus2.pix_valid = 0;

    // Illegal requests
    q.delete(); e0 = nerr;
    bus.req_valid = 1; bus.req_x0 = 10; bus.req_y0 = 0; bus.req_x1 = 9; bus.req_y1 = 0;
    tick();
    check("ill1_err", bus.err, 1);
    check("ill1_tx_valid", bus.tx_valid, 0);
    check("ill1_busy", bus.busy, 0);
    check("ill1_req_ready", bus.req_ready, 1);
    bus.req_x0 = 0; bus.req_x1 = 132;
    tick();
    bus.req_valid = 0;
    check("ill2_err", bus.err, 1);
    check("ill2_tx_valid", bus.tx_valid, 0);
    check("ill2_busy", bus.busy, 0);
    tick();
    check("ill_err_clear", bus.err, 0);
    tick();
    check("ill_err_pulses", nerr - e0, 2);
    check("ill_no_words", q.size(), 0);

    // 2x2 with tx_ready toggling and pixel gaps
    q.delete(); base = pcnt; d0 = ndone;
    bus.tx_ready = 1; bus.pix_valid = 0;
    req(8'd0, 8'd0, 8'd1, 8'd1);
    last = 0; gap = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      bus.tx_ready = (c % 3) != 1;
      cons = pcnt - base;
      if (cons != last) begin
        gap = 3;
        last = cons;
      end
      if (gap > 0) begin
        gap--;
        bus.pix_valid = 0;
      end else if (cons < 4) begin
        bus.pix_valid = 1;
        bus.pix_data = pixtab[cons];
      end else begin
        bus.pix_valid = 0;
      end
      tick();
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    bus.pix_valid = 0; bus.tx_ready = 1;
    check("r2_done_seen", seen, 1);
    tick(); tick();
    check("r2_len", q.size(), 19);
    if (q.size() == 19)
      for (int k = 0; k < 19; k++) check($sformatf("r2_w%0d", k), q[k], e_2x2[k]);
    check("r2_pix_consumed", pcnt - base, 4);
    check("r2_done_pulses", ndone - d0, 1);

    // 4x4 stalled on the 3rd pixel, then reset mid-transfer
    q.delete(); base = pcnt;
    bus.tx_ready = 1; bus.pix_valid = 1; bus.pix_data = 16'hABCD;
    req(8'd0, 8'd0, 8'd3, 8'd3);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (pcnt - base >= 3) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("stall_reached", seen, 1);
    bus.tx_ready = 0;
    repeat (10) tick();
    check("stall_word", bus.tx_word, 9'h1AB);
    check("stall_valid", bus.tx_valid, 1);
    check("stall_no_pix", pcnt - base, 3);
    rst = 1;
    #1;
    check("mrst_tx_valid", bus.tx_valid, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_tx_word", bus.tx_word, 0);
    q.delete();
    tick(); tick();
    rst = 0;
    bus.tx_ready = 1;
    tick(); tick();
    check("mrst_no_words", q.size(), 0);
    base = pcnt; d0 = ndone;
    req(8'd0, 8'd0, 8'd0, 8'd0);
    check("post_rst_first_word", bus.tx_word, 9'h02A);
    check("post_rst_valid", bus.tx_valid, 1);
    wait_done(200, seen, busy_low);
    check("post_rst_done_seen", seen, 1);
    tick(); tick();
    check("post_rst_len", q.size(), 13);
    if (q.size() == 13) begin
      check("post_rst_w0", q[0], 9'h02A);
      check("post_rst_w11", q[11], 9'h1AB);
      check("post_rst_w12", q[12], 9'h1CD);
    end
    check("post_rst_pix", pcnt - base, 1);
    check("post_rst_done_pulses", ndone - d0, 1);

    // Request held during an active transfer
    q.delete(); base = pcnt; d0 = ndone;
    bus.tx_ready = 1; bus.pix_valid = 1; bus.pix_data = 16'h5A3C;
    bus.req_valid = 1; bus.req_x0 = 0; bus.req_y0 = 0; bus.req_x1 = 1; bus.req_y1 = 0;
    tick();
    bus.req_x0 = 3; bus.req_y0 = 3; bus.req_x1 = 3; bus.req_y1 = 3;
    check("hold_req_ready", bus.req_ready, 0);
    wait_done(200, seen, busy_low);
    check("hold_done_seen", seen, 1);
    check("hold_first_len", q.size(), 15);
    check("hold_req_ready_done", bus.req_ready, 1);
    tick();
    bus.req_valid = 0;
    check("hold_second_word", bus.tx_word, 9'h02A);
    check("hold_second_busy", bus.busy, 1);
    wait_done(200, seen, busy_low);
    check("hold_second_done", seen, 1);
    tick(); tick();
    check("hold_total_len", q.size(), 28);
    if (q.size() == 28) begin
      check("hold_a_x1", q[4], 9'h101);
      check("hold_a_y1", q[9], 9'h100);
      check("hold_b_x0", q[17], 9'h103);
      check("hold_b_y0", q[22], 9'h103);
      check("hold_b_lo", q[27], 9'h13C);
    end
    check("hold_pix", pcnt - base, 3);
    check("hold_done_pulses", ndone - d0, 2);
    bus.pix_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/lcd_rect_writer.md
Name: lcd_rect_writer

Overview:
- Command sequencer in front of the ST7735 SPI serializer.
- Takes a rectangle-write request, emits the window commands CASET, RASET and RAMWR as 9-bit {dc,byte} words, then streams RGB565 pixels as two bytes each.
- Sits between pixel sources (frame RAM reader, fill engine) and the byte-level SPI shifter.
- Downstream shifter consumes one word per tx_valid&tx_ready handshake.

Parameters:
- LCD_W, 132, screen width in pixels; x1 must be < LCD_W.
- LCD_H, 162, screen height in pixels; y1 must be < LCD_H.
- COL_OFS, 0, panel column offset added to x0/x1 in CASET data, modulo 256.
- ROW_OFS, 0, panel row offset added to y0/y1 in RASET data, modulo 256.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active high.
- req_valid  in  1  rectangle request present.
- req_ready  out  1  high when a request can be accepted.
- req_x0  in  8  first column.
- req_y0  in  8  first row.
- req_x1  in  8  last column, inclusive.
- req_y1  in  8  last row, inclusive.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  pixel accepted this cycle when pix_valid is also high.
- pix_data  in  16  RGB565 pixel.
- tx_valid  out  1  tx_word valid.
- tx_ready  in  1  serializer accepts tx_word.
- tx_word  out  9  bit8 = dc (0 command, 1 data), bits7:0 = byte.
- busy  out  1  high from request accept through done.
- done  out  1  one-cycle pulse when the last word is accepted.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values (asynchronous, rst high): state IDLE, tx_valid=0, tx_word=0, busy=0, done=0, err=0, all counters 0. Reset mid-transfer abandons it; no further words are issued.
- req_ready = (state==IDLE), combinational. A request is accepted on req_valid&req_ready.
- Validation at accept: the request is legal iff x0<=x1, x1<LCD_W, y0<=y1 and y1<LCD_H.
  - Illegal: err pulses the next cycle, state stays IDLE, busy stays 0, no tx words.
  - Legal: coordinates are latched; pixel count N = (x1-x0+1)*(y1-y0+1), 16-bit, max 21384.
- States: IDLE -> HDR -> PIX_HI <-> PIX_LO -> IDLE.
- HDR issues 11 words in order:
  - 0x02A, 0x100, 0x100|(x0+COL_OFS), 0x100, 0x100|(x1+COL_OFS)
  - 0x02B, 0x100, 0x100|(y0+ROW_OFS), 0x100, 0x100|(y1+ROW_OFS)
  - 0x02C
- tx_valid rises the cycle after request accept, carrying word 0.
- Output register rules:
  - tx_word is held stable while tx_valid & !tx_ready.
  - A new word may load in the same cycle the current word is accepted, giving back-to-back throughput of 1 word/cycle.
- PIX_HI:
  - pix_ready = (state==PIX_HI) & (!tx_valid | tx_ready), combinational.
  - On pix_valid&pix_ready: load tx_word = {1'b1, pix_data[15:8]}, latch pix_data[7:0], go to PIX_LO.
  - If no pixel is available, tx_valid drops to 0 after the pending word is accepted; there is no timeout.
- PIX_LO:
  - pix_ready = 0.
  - When the output register is free: load {1'b1, low byte} and decrement the remaining count.
  - If the remaining count reaches 0, go to a drain step; otherwise return to PIX_HI.
- Completion: done pulses, and busy falls, in the cycle after the final low-byte word handshake completes. State then returns to IDLE, and req_ready is high that same cycle.
- Boundary cases:
  - 1x1 rectangle: 11 header words + 2 pixel words; exactly one pixel consumed.
  - Full screen: 21384 pixels, 42768 pixel words; the counter must not wrap.
  - tx_ready held low indefinitely: tx_word frozen, no pixel consumed.
  - req_valid while busy: ignored (req_ready=0).
  - Extra pix_valid after N pixels: not consumed.
  - Coordinate offsets wrap modulo 256; this is not an error.

Test Plan:
- Rect (0,0)-(131,161), COL_OFS=ROW_OFS=0, tx_ready=1, constant pix 0xF800 -> header words 02A,100,100,100,183,02B,100,100,100,1A1,02C; then 21384 pairs 1F8,100; one done pulse; busy high throughout.
- Rect (5,7)-(5,7), COL_OFS=2, ROW_OFS=1, pix 0x07E0 -> CASET data 100,107,100,107; RASET data 100,108,100,108; words 02C,107,1E0; exactly 1 pixel consumed; done.
- Rect (10,0)-(9,0), then (0,0)-(132,0) -> err pulse for each; no tx_valid; req_ready stays 1.
- 2x2 rect with tx_ready toggling 1-0-1 and pix_valid gaps of 3 cycles -> tx_word stable while stalled; byte order hi,lo per pixel; 8 pixel words total; no pixels dropped or duplicated.
- Assert rst during the 3rd pixel of a 4x4 rect -> tx_valid=0, busy=0 immediately; after release a new 1x1 request runs cleanly from word 0x02A.
- req_valid held high during an active transfer with different coordinates -> ignored; second request accepted only on the cycle after done.
